// File: rtl/music_pkg.sv
// Shared definitions for the step sequencer: FSM states, note encoding,
// tempo and pitch tables, and the melody ROM.
package music_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef logic [4:0] note_code_t;

  localparam int ROM_DEPTH = 32;

  function automatic logic [4:0] tempo_frames(input logic [1:0] tempo);
    logic [4:0] frames;
    case (tempo)
      2'b00:   frames = 5'd16;
      2'b01:   frames = 5'd12;
      2'b10:   frames = 5'd8;
      default: frames = 5'd6;
    endcase
    return frames;
  endfunction

  function automatic logic is_rest(input note_code_t code);
    return (code[3:0] == 4'd0) || (code[3:0] > 4'd12);
  endfunction

  // Octave-0 half period in clocks, round(clk_hz / (2*f)); f held in micro-hertz.
  function automatic logic [15:0] pitch_half_period(input longint clk_hz, input logic [3:0] pitch);
    longint f_uhz;
    case (pitch)
      4'd1:    f_uhz = 64'd261625565;
      4'd2:    f_uhz = 64'd277182631;
      4'd3:    f_uhz = 64'd293664768;
      4'd4:    f_uhz = 64'd311126984;
      4'd5:    f_uhz = 64'd329627557;
      4'd6:    f_uhz = 64'd349228231;
      4'd7:    f_uhz = 64'd369994423;
      4'd8:    f_uhz = 64'd391995436;
      4'd9:    f_uhz = 64'd415304698;
      4'd10:   f_uhz = 64'd440000000;
      4'd11:   f_uhz = 64'd466163762;
      4'd12:   f_uhz = 64'd493883301;
      default: f_uhz = 64'd0;
    endcase
    if (f_uhz == 64'd0) return 16'd0;
    return 16'((clk_hz * 64'd1000000 + f_uhz) / (64'd2 * f_uhz));
  endfunction

  localparam note_code_t SEQ_ROM [ROM_DEPTH] = '{
    5'h0A, 5'h0C, 5'h11, 5'h0C, 5'h0A, 5'h1C, 5'h05, 5'h00,
    5'h01, 5'h03, 5'h05, 5'h06, 5'h08, 5'h0A, 5'h0C, 5'h00,
    5'h18, 5'h15, 5'h11, 5'h0C, 5'h0A, 5'h08, 5'h0A, 5'h0E,
    5'h05, 5'h08, 5'h0A, 5'h0C, 5'h11, 5'h0C, 5'h0A, 5'h00
  };

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: a half-period down-counter that flips the wave each
// time it expires. A zero half period (rest) freezes the counter.
module tone_gen
  import music_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [15:0] half_period,
  input  logic        run,
  input  logic        reload,
  output logic        wave
);

  logic [15:0] cnt_q, cnt_d;
  logic        wave_q, wave_d;

  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (ena) begin
      if (reload) begin
        cnt_d  = half_period;
        wave_d = 1'b0;
      end else if (run && (half_period != 16'd0)) begin
        // Counter runs H..1, so the wave flips exactly every H clocks.
        if (cnt_q <= 16'd1) begin
          cnt_d  = half_period;
          wave_d = ~wave_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 16'd0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q & run;

endmodule

// File: rtl/music_seq.sv
// Frame-paced step sequencer: STOP/PLAY/HOLD control, frame and step counters,
// melody ROM lookup and a tone generator for the current note.
module music_seq #(
  parameter int unsigned CLK_HZ  = 25175000,
  parameter int unsigned SEQ_LEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       frame_tick,
  input  logic       play,
  input  logic       restart,
  input  logic [1:0] tempo,
  output logic       audio_out,
  output logic [4:0] note_code,
  output logic [4:0] step_idx,
  output logic       beat_pulse,
  output logic       playing
);
  import music_pkg::*;

  localparam logic [4:0] STEP_MASK = 5'(SEQ_LEN - 1);

  state_e      state_q, state_d;
  logic [4:0]  step_q, step_d;
  logic [4:0]  frame_q, frame_d;
  logic [1:0]  tempo_q, tempo_d;
  logic        beat_q, beat_d;
  logic        reload;
  note_code_t  sel_note;
  logic [15:0] half_period;
  logic        tone_wave;
  logic [15:0] half_tbl [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_pitch
    assign half_tbl[gi] = pitch_half_period(longint'(CLK_HZ), 4'(gi));
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    frame_d = frame_q;
    tempo_d = tempo_q;
    beat_d  = beat_q;
    reload  = 1'b0;
    if (ena) begin
      beat_d = 1'b0;
      // restart outranks a coincident frame_tick, so no beat can slip out.
      if (restart) begin
        step_d  = 5'd0;
        frame_d = 5'd0;
        reload  = 1'b1;
      end else if ((state_q == ST_PLAY) && frame_tick) begin
        if (frame_q == tempo_frames(tempo_q) - 5'd1) begin
          frame_d = 5'd0;
          step_d  = (step_q + 5'd1) & STEP_MASK;
          tempo_d = tempo;
          beat_d  = 1'b1;
          reload  = 1'b1;
        end else begin
          frame_d = frame_q + 5'd1;
        end
      end
      case (state_q)
        ST_STOP: if (play) begin
          state_d = ST_PLAY;
          tempo_d = tempo;
          reload  = 1'b1;
        end
        ST_PLAY: if (!play) state_d = ST_HOLD;
        ST_HOLD: if (play) state_d = ST_PLAY;
        default: state_d = ST_STOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      step_q  <= 5'd0;
      frame_q <= 5'd0;
      tempo_q <= 2'b00;
      beat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      frame_q <= frame_d;
      tempo_q <= tempo_d;
      beat_q  <= beat_d;
    end
  end

  // On a reload the counter must pick up the half period of the step being entered.
  always_comb begin
    sel_note    = reload ? SEQ_ROM[step_d] : SEQ_ROM[step_q];
    half_period = half_tbl[sel_note[3:0]] >> sel_note[4];
  end

  tone_gen u_tone (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .half_period (half_period),
    .run         (state_q == ST_PLAY),
    .reload      (reload),
    .wave        (tone_wave)
  );

  assign note_code  = SEQ_ROM[step_q];
  assign step_idx   = step_q;
  assign playing    = (state_q == ST_PLAY);
  assign beat_pulse = beat_q & ena;
  assign audio_out  = tone_wave & ~is_rest(note_code);

endmodule

// File: tb/tb_music_seq.sv
// Bench for music_seq: a behavioural model scored every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_music_seq;

  localparam int CLK_HZ = 25175000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       frame_tick = 1'b0;
  logic       play = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] tempo = 2'b00;
  logic       audio_out;
  logic [4:0] note_code;
  logic [4:0] step_idx;
  logic       beat_pulse;
  logic       playing;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit hold_mon = 1'b0;
  int beats = 0;
  int hold_hi = 0;
  int hi31 = 0;

  int rom [32] = '{
    'h0A, 'h0C, 'h11, 'h0C, 'h0A, 'h1C, 'h05, 'h00,
    'h01, 'h03, 'h05, 'h06, 'h08, 'h0A, 'h0C, 'h00,
    'h18, 'h15, 'h11, 'h0C, 'h0A, 'h08, 'h0A, 'h0E,
    'h05, 'h08, 'h0A, 'h0C, 'h11, 'h0C, 'h0A, 'h00
  };

  // Model state: 0 stop, 1 play, 2 hold; m_k = tone clocks elapsed since last reload.
  int m_st = 0, m_step = 0, m_fr = 0, m_len = 16, m_k = 0;
  bit m_beat = 1'b0;
  bit adv;

  always #5 clk = ~clk;

  music_seq #(.CLK_HZ(CLK_HZ), .SEQ_LEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .frame_tick (frame_tick),
    .play       (play),
    .restart    (restart),
    .tempo      (tempo),
    .audio_out  (audio_out),
    .note_code  (note_code),
    .step_idx   (step_idx),
    .beat_pulse (beat_pulse),
    .playing    (playing)
  );

  function automatic int frames_of(input int t);
    case (t)
      0:       return 16;
      1:       return 12;
      2:       return 8;
      default: return 6;
    endcase
  endfunction

  function automatic int half_of(input int code);
    int  pitch;
    int  oct;
    real f;
    pitch = code % 16;
    oct   = code / 16;
    if (pitch == 0 || pitch > 12) return 0;
    f = 440.0 * (2.0 ** ((pitch - 10) / 12.0));
    return $rtoi(CLK_HZ / (2.0 * f) + 0.5) >> oct;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_st = 0; m_step = 0; m_fr = 0; m_len = 16; m_k = 0; m_beat = 1'b0;
      end else if (ena) begin
        adv = 1'b0;
        if (restart) begin
          m_step = 0; m_fr = 0; m_k = 0;
        end else if (m_st == 1 && frame_tick) begin
          if (m_fr + 1 == m_len) begin
            m_fr = 0; m_step = (m_step + 1) % 32; m_len = frames_of(int'(tempo));
            m_k = 0; adv = 1'b1;
          end else begin
            m_fr++;
          end
        end
        if (m_st == 1 && !restart && !adv && half_of(rom[m_step]) != 0) m_k++;
        if (m_st == 0 && play) begin
          m_st = 1; m_len = frames_of(int'(tempo)); m_k = 0;
        end else if (m_st == 1 && !play) begin
          m_st = 2;
        end else if (m_st == 2 && play) begin
          m_st = 1;
        end
        m_beat = adv;
      end
    end
  end

  initial begin
    int  h;
    bit  e_aud, e_beat, e_play;
    forever begin
      @(negedge clk);
      if (beat_pulse) begin
        beats++;
        $display("beat %0d: step=%0d note=%02h", beats, step_idx, note_code);
      end
      if (hold_mon && audio_out) hold_hi++;
      if (step_idx == 5'd31 && audio_out) hi31++;
      if (cmp_en) begin
        h      = half_of(rom[m_step]);
        e_aud  = (m_st == 1 && h != 0) ? (((m_k / h) % 2) == 1) : 1'b0;
        e_beat = m_beat && ena;
        e_play = (m_st == 1);
        checks++;
        if (audio_out !== e_aud || note_code !== 5'(rom[m_step]) || step_idx !== 5'(m_step)
            || beat_pulse !== e_beat || playing !== e_play) begin
          errors++;
          $display("FAIL model t=%0t got aud=%b note=%02h step=%0d beat=%b play=%b want aud=%b note=%02h step=%0d beat=%b play=%b",
                   $time, audio_out, note_code, step_idx, beat_pulse, playing,
                   e_aud, rom[m_step], m_step, e_beat, e_play);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      repeat (3) cyc();
    end
  endtask

  initial begin
    int n;
    int b0;
    cyc();
    cmp_en = 1'b1;
    repeat (2) cyc();
    check("rst_step", int'(step_idx), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_audio", int'(audio_out), 0);
    check("rst_beat", int'(beat_pulse), 0);
    check("rst_note", int'(note_code), 'h0A);
    rst_n = 1'b1;
    repeat (3) cyc();
    check("stop_idle", int'(playing), 0);

    // Tone timing at step 0 (A, 28608 clocks per half period), no frame ticks.
    tempo = 2'b11;
    play  = 1'b1;
    cyc();
    check("enter_play", int'(playing), 1);
    n = 0;
    while (!audio_out && n < 30000) begin cyc(); n++; end
    check("tone_first_rise", n, 28608);
    n = 0;
    while (audio_out && n < 30000) begin cyc(); n++; end
    check("tone_high_time", n, 28608);

    // Six ticks at tempo 11 advance to step 1 with a single beat.
    b0 = beats;
    frames(5);
    check("step0_before6", int'(step_idx), 0);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check("step_after6", int'(step_idx), 1);
    check("note_after6", int'(note_code), 'h0C);
    check("beat_after6", int'(beat_pulse), 1);
    cyc();
    check("beat_one_cycle", int'(beat_pulse), 0);
    repeat (2) cyc();
    check("one_beat", beats - b0, 1);

    // A mid-step tempo change only takes effect from the next step.
    frames(2);
    tempo = 2'b00;
    frames(4);
    check("tempo_mid_ignored", int'(step_idx), 2);
    frames(10);
    tempo = 2'b01;
    frames(5);
    check("len16_not_yet", int'(step_idx), 2);
    frames(1);
    check("len16_done", int'(step_idx), 3);
    frames(11);
    tempo = 2'b11;
    check("len12_not_yet", int'(step_idx), 3);
    frames(1);
    check("len12_done", int'(step_idx), 4);

    // Pause mid-step: 3 frames in, hold for 20 ticks, then the remaining 3 finish it.
    frames(3);
    play = 1'b0;
    repeat (2) cyc();
    hold_mon = 1'b1;
    frames(20);
    hold_mon = 1'b0;
    check("hold_step", int'(step_idx), 4);
    check("hold_playing", int'(playing), 0);
    check("hold_audio_hi", hold_hi, 0);
    play = 1'b1;
    cyc();
    frames(2);
    check("resume_not_yet", int'(step_idx), 4);
    frames(1);
    check("resume_done", int'(step_idx), 5);

    // Asynchronous reset mid-tone at step 5 (B one octave up: 12743 clocks).
    n = 0;
    while (!audio_out && n < 14000) begin cyc(); n++; end
    check("step5_tone_high", int'(audio_out), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_step", int'(step_idx), 0);
    check("arst_playing", int'(playing), 0);
    check("arst_audio", int'(audio_out), 0);
    check("arst_beat", int'(beat_pulse), 0);
    check("arst_note", int'(note_code), 'h0A);
    play = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    check("post_rst_stop", int'(playing), 0);
    play = 1'b1;
    cyc();
    check("post_rst_play", int'(playing), 1);

    // Walk to the rest at step 31 and wrap.
    frames(186);
    check("reach31", int'(step_idx), 31);
    frames(5);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check("wrap_step", int'(step_idx), 0);
    check("wrap_beat", int'(beat_pulse), 1);
    repeat (3) cyc();
    check("rest31_audio_hi", hi31, 0);

    // restart coincident with the final tick of step 1.
    frames(6);
    frames(5);
    b0 = beats;
    frame_tick = 1'b1;
    restart    = 1'b1;
    cyc();
    frame_tick = 1'b0;
    restart    = 1'b0;
    check("restart_step", int'(step_idx), 0);
    check("restart_no_beat", int'(beat_pulse), 0);
    repeat (3) cyc();
    check("restart_beats", beats - b0, 0);
    frames(5);
    check("restart_cnt_clear", int'(step_idx), 0);
    frames(1);
    check("restart_then_adv", int'(step_idx), 1);

    // ena low: ticks and restart ignored, counters hold.
    frames(2);
    ena = 1'b0;
    frames(10);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("ena0_step", int'(step_idx), 1);
    check("ena0_playing", int'(playing), 1);
    ena = 1'b1;
    frames(3);
    check("ena1_not_yet", int'(step_idx), 1);
    frames(1);
    check("ena1_done", int'(step_idx), 2);

    repeat (5) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/music_seq.md
MUSIC_SEQ -- requirements
Module: music_seq

Interface
REQ-001 SHALL expose parameter CLK_HZ, default 25175000, meaning the system clock frequency used to derive the pitch table.
REQ-002 SHALL expose parameter SEQ_LEN, default 32, meaning the number of sequence steps; it SHALL be a power of two.
REQ-003 clk  input  1  system (pixel) clock; the only clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  design enable; when 0, all state SHALL hold.
REQ-006 frame_tick  input  1  one-cycle pulse per video frame (60 Hz) from VGA timing.
REQ-007 play  input  1  level; 1 = run, 0 = pause.
REQ-008 restart  input  1  one-cycle pulse; return to step 0.
REQ-009 tempo  input  2  frames per step: 00=16, 01=12, 10=8, 11=6.
REQ-010 audio_out  output  1  square-wave tone.
REQ-011 note_code  output  5  current note: [4]=octave-up, [3:0]=pitch (0 rest, 1..12 = C..B, 13..15 treated as rest).
REQ-012 step_idx  output  5  current sequence step.
REQ-013 beat_pulse  output  1  one-cycle pulse on each step advance.
REQ-014 playing  output  1  1 while in the PLAY state.

Function
REQ-015 The state machine SHALL have the states STOP, PLAY and HOLD.
REQ-016 Transitions: STOP->PLAY on play=1; PLAY->HOLD on play=0; HOLD->PLAY on play=1; any state->STOP only via reset.
REQ-017 In PLAY, a frame counter SHALL increment on each frame_tick; at frame_tick with count = len-1, the counter SHALL clear, step_idx SHALL advance modulo SEQ_LEN (31->0 wrap), and beat_pulse SHALL assert the next cycle for exactly one cycle.
REQ-018 tempo SHALL be latched at each step boundary and on entering PLAY from STOP; mid-step changes SHALL NOT alter the current step.
REQ-019 In HOLD and STOP, the frame counter, step_idx and tone phase SHALL hold, and audio_out SHALL be 0.
REQ-020 restart SHALL set step_idx=0, clear the frame counter and reset the tone phase without changing state; restart SHALL win over a simultaneous frame_tick.
REQ-021 note_code SHALL equal ROM[step_idx] combinationally from registered step_idx (zero latency).
REQ-022 Tone: a 16-bit down-counter SHALL load half-period H; at 0 it SHALL toggle audio_out and reload H; H(octave 1) = H(octave 0)>>1.
REQ-023 On each step advance, the tone counter SHALL reload the new H and audio_out SHALL be 0 on the next cycle.
REQ-024 A rest code SHALL force audio_out=0 and hold the tone counter.
REQ-025 Pitch table SHALL be round(CLK_HZ/(2*f)), with A (pitch 10, octave 0, 440 Hz) = 28608 at the default CLK_HZ.
REQ-026 The sequence ROM SHALL have step0=0x0A, step1=0x0C, and step31=0x00 (rest); the remaining steps are a team-chosen melody.
REQ-027 When ena=0, all registers SHALL hold, pulses arriving during that time SHALL be ignored, and beat_pulse SHALL be 0.

Reset
REQ-028 While rst_n=0: state=STOP, step_idx=0, frame counter=0, tone counter=0, latched tempo=00, audio_out=0, beat_pulse=0, playing=0.
REQ-029 Reset asserted mid-step or mid-tone SHALL take effect immediately (asynchronously); after release, the block SHALL stay in STOP until play=1 is sampled.

Structure
REQ-030 A shared package music_pkg SHALL hold: the state enum, the note_code typedef, the tempo-to-frames table, the pitch half-period function of CLK_HZ, and the sequence ROM constant.
REQ-031 A sub-module tone_gen SHALL contain the half-period down-counter and toggle, with inputs half_period, run and reload, and output wave; music_seq SHALL contain the FSM, step and frame counters and ROM lookup.

Verification
REQ-032 Reset, then play=1, tempo=11, 6 frame_ticks -> step_idx 0->1 after the 6th tick; one beat_pulse; note_code 0x0A->0x0C.
REQ-033 PLAY at step 0 -> audio_out toggles every 28608 clk cycles (+/-0); period 57216.
REQ-034 Run to step 31 (rest) -> audio_out=0 throughout; the next boundary wraps step_idx to 0 with beat_pulse.
REQ-035 play=0 mid-step, 20 frame_ticks, then play=1 -> step_idx unchanged and audio_out=0 during HOLD; the step completes after the remaining frames.
REQ-036 restart coincident with frame_tick at count len-1 -> step_idx=0, no beat_pulse; ena=0 for 10 frame_ticks -> no state change.
REQ-037 rst_n pulsed low asynchronously mid-tone at step 5 -> all outputs 0 immediately; STOP after release.
